// File: rtl/ans_encoder.sv
// Streaming rANS encoder: renormalise, divide x by f, fold in the symbol, then flush the state.
// Optional ANS_ENC_SYM_CHECK_EN rejects out-of-range or zero-count symbols and raises a sticky err.
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 4
`endif
`ifndef SYM_COUNT
`define SYM_COUNT 4
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif

module ans_encoder (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             en,
    input  logic [`SYM_WIDTH-1:0]                            in,
    input  logic                                             in_vld,
    output logic                                             in_rdy,
    input  logic                                             flush,
    output logic [`SYM_WIDTH-1:0]                            out,
    output logic                                             out_vld,
    input  logic                                             out_rdy,
    input  logic [`CNT_WIDTH*`SYM_COUNT-1:0]                 counts_unpacked,
    input  logic [(`CNT_WIDTH+`SYM_WIDTH)*`SYM_COUNT-1:0]    cumulative_unpacked,
    output logic                                             done,
    output logic                                             err
);
    localparam int SYMW = `SYM_WIDTH;
    localparam int CW   = `CNT_WIDTH;
    localparam int SYMC = `SYM_COUNT;
    localparam int STW  = `STATE_WIDTH;
    localparam int MW   = CW + SYMW;
    localparam int RW   = CW + 1;
    localparam int LW   = STW + 1;
    localparam int CTW  = $clog2(STW);

    typedef enum logic [2:0] {IDLE, RENORM, DIVIDE, UPDATE, FLUSH} state_t;

    function automatic logic [CW-1:0] count_of(input logic [SYMW-1:0] s,
                                               input logic [CW*SYMC-1:0] tbl);
        count_of = '0;
        for (int j = 0; j < SYMC; j++)
            if (s == SYMW'(j)) count_of = tbl[j*CW +: CW];
    endfunction

    function automatic logic [MW-1:0] cum_of(input logic [SYMW-1:0] s,
                                             input logic [MW*SYMC-1:0] tbl);
        cum_of = '0;
        for (int j = 0; j < SYMC; j++)
            if (s == SYMW'(j)) cum_of = tbl[j*MW +: MW];
    endfunction

    state_t           state_q, state_d;
    logic [STW-1:0]   x_q, x_d;
    logic [SYMW-1:0]  sym_q, sym_d;
    logic [STW-1:0]   quo_q, quo_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [CTW-1:0]   cnt_q, cnt_d;
    logic             init_q, init_d;
    logic             done_q, done_d;

    logic [CW-1:0]    f;
    logic [MW-1:0]    m;
    logic [MW-1:0]    cum_lo;
    logic [LW-1:0]    f_lim;
    logic [RW-1:0]    rem_sh;
    logic             div_ge;
    logic [STW-1:0]   x_upd;
    logic [3:0]       nib;

    assign f      = count_of(sym_q, counts_unpacked);
    assign m      = cumulative_unpacked[(SYMC-1)*MW +: MW];
    assign cum_lo = cum_of(sym_q, cumulative_unpacked) - MW'(f);
    assign f_lim  = LW'(f) << 4;

    // One restoring-division step: bring down the next dividend bit and try to subtract f.
    assign rem_sh = {rem_q, quo_q[STW-1]};
    assign div_ge = rem_sh >= {1'b0, f};

    // Product wraps modulo 2^STW, which is exactly the required truncation.
    assign x_upd  = quo_q * STW'(m) + STW'(rem_q) + STW'(cum_lo);

`ifdef ANS_ENC_SYM_CHECK_EN
    logic err_q, err_d, skip_q, skip_d;
    logic in_bad;
    assign in_bad = (int'(in) >= SYMC) || (count_of(in, counts_unpacked) == '0);
    assign err    = err_q;
`else
    assign err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        sym_d   = sym_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        init_d  = 1'b1;
        done_d  = 1'b0;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        nib     = '0;
`ifdef ANS_ENC_SYM_CHECK_EN
        err_d   = err_q;
        skip_d  = skip_q;
`endif
        // The state only becomes M on the first clock after reset releases.
        if (!init_q) x_d = STW'(m);

        case (state_q)
            IDLE: begin
                in_rdy = en;
                if (in_vld && in_rdy) begin
                    sym_d   = in;
                    state_d = RENORM;
`ifdef ANS_ENC_SYM_CHECK_EN
                    if (in_bad) begin
                        err_d   = 1'b1;
                        skip_d  = 1'b1;
                        state_d = UPDATE;
                    end
`endif
                end else if (en && flush) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end
            end
            RENORM: begin
                if ({1'b0, x_q} >= f_lim) begin
                    out_vld = en;
                    nib     = x_q[3:0];
                    if (out_vld && out_rdy) x_d = x_q >> 4;
                end else if (en) begin
                    quo_d   = x_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                if (en) begin
                    quo_d = {quo_q[STW-2:0], div_ge};
                    rem_d = div_ge ? CW'(rem_sh - {1'b0, f}) : rem_sh[CW-1:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CTW'(STW-1)) state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (en) begin
                    x_d     = x_upd;
                    state_d = IDLE;
`ifdef ANS_ENC_SYM_CHECK_EN
                    if (skip_q) x_d = x_q;
                    skip_d = 1'b0;
`endif
                end
            end
            FLUSH: begin
                out_vld = en;
                nib     = x_q[STW-1 -: 4];
                if (out_vld && out_rdy) begin
                    x_d   = x_q << 4;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CTW'(STW/4-1)) begin
                        x_d     = STW'(m);
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out  = out_vld ? SYMW'(nib) : '0;
    assign done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            sym_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            init_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ANS_ENC_SYM_CHECK_EN
            err_q   <= 1'b0;
            skip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            sym_q   <= sym_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            done_q  <= done_d;
`ifdef ANS_ENC_SYM_CHECK_EN
            err_q   <= err_d;
            skip_q  <= skip_d;
`endif
        end
    end
endmodule

// File: tb/tb_ans_encoder.sv
// Directed bench for ans_encoder with table counts {4,4,4,4}, cumulative {4,8,12,16}, M = 16.
module tb_ans_encoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  in_sym;
    logic        in_vld;
    logic        in_rdy;
    logic        flush;
    logic [3:0]  out;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] counts;
    logic [31:0] cumulative;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int en_off_at = -1;
    int en_on_at = -1;
    logic [3:0] nib_q[$];

    ans_encoder dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .en                  (en),
        .in                  (in_sym),
        .in_vld              (in_vld),
        .in_rdy              (in_rdy),
        .flush               (flush),
        .out                 (out),
        .out_vld             (out_vld),
        .out_rdy             (out_rdy),
        .counts_unpacked     (counts),
        .cumulative_unpacked (cumulative),
        .done                (done),
        .err                 (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_vld && out_rdy) nib_q.push_back(out);
        if (done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!in_rdy && n < 100) begin
            tick();
            n++;
            if (n == en_off_at) en = 1'b0;
            if (n == en_on_at)  en = 1'b1;
        end
    endtask

    task automatic put_sym(input logic [3:0] s);
        in_sym = s;
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
    endtask

    // exp holds the expected nibbles as hex digits, first emitted on the left.
    task automatic check_stream(input string tag, input int base, input int len, input logic [15:0] exp);
        check({tag, "_len"}, nib_q.size() - base, len);
        for (int i = 0; i < len; i++)
            if (base + i < nib_q.size())
                check($sformatf("%s[%0d]", tag, i), nib_q[base+i], exp[4*(len-1-i) +: 4]);
    endtask

    task automatic do_flush(input string tag, input logic [15:0] exp);
        int base, d0, n;
        base = nib_q.size();
        d0 = done_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle(n);
        tick();
        tick();
        check({tag, "_idle"}, in_rdy, 1);
        check_stream(tag, base, 4, exp);
        check({tag, "_done"}, done_cnt - d0, 1);
    endtask

    initial begin
        int lat, base;
        rst_n = 1'b0; en = 1'b1; in_sym = '0; in_vld = 1'b0; flush = 1'b0; out_rdy = 1'b1;
        counts = {4'd4, 4'd4, 4'd4, 4'd4};
        cumulative = {8'd16, 8'd12, 8'd8, 8'd4};
        tick(); tick();
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_vld", out_vld, 0);
        check("rst_out", out, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick(); tick();

        // Symbol 0 from x=16: no renorm, x becomes 64, ready after 18 cycles.
        base = nib_q.size();
        put_sym(4'd0);
        wait_idle(lat);
        check("sym0_latency", lat, 18);
        check_stream("sym0_nibs", base, 0, 16'h0);
        // Symbol 1 from x=64: one nibble 0, x becomes 20.
        put_sym(4'd1);
        wait_idle(lat);
        check_stream("sym1_nibs", base, 1, 16'h0);
        do_flush("flush1", 16'h0014);

        // Same pair with en low for 4 cycles during the divide and a stalled nibble.
        en_off_at = 3; en_on_at = 7;
        put_sym(4'd0);
        wait_idle(lat);
        en_off_at = -1; en_on_at = -1;
        check("en_hold_latency", lat, 22);
        base = nib_q.size();
        out_rdy = 1'b0;
        put_sym(4'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall0_vld%0d", i), out_vld, 1);
            check($sformatf("stall0_out%0d", i), out, 4'h0);
            check($sformatf("stall0_rdy%0d", i), in_rdy, 0);
            tick();
        end
        out_rdy = 1'b1;
        wait_idle(lat);
        check_stream("stall0_nibs", base, 1, 16'h0);
        do_flush("flush2", 16'h0014);

        // Symbol 3 gives x=76 (0x4C); symbol 2 then emits 0xC under stall, x=24.
        base = nib_q.size();
        put_sym(4'd3);
        wait_idle(lat);
        out_rdy = 1'b0;
        put_sym(4'd2);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stallC_vld%0d", i), out_vld, 1);
            check($sformatf("stallC_out%0d", i), out, 4'hC);
            tick();
        end
        out_rdy = 1'b1;
        wait_idle(lat);
        check_stream("stallC_nibs", base, 1, 16'hC);
        do_flush("flush3", 16'h0018);

        // Zero-count symbol.
        counts[11:8] = 4'd0;
        base = nib_q.size();
`ifdef ANS_ENC_SYM_CHECK_EN
        put_sym(4'd2);
        wait_idle(lat);
        check("bad_latency", lat, 1);
        check("bad_err", err, 1);
        check_stream("bad_nibs", base, 0, 16'h0);
        counts[11:8] = 4'd4;
        do_flush("flush_bad", 16'h0010);
        check("bad_err_sticky", err, 1);
`else
        put_sym(4'd2);
        tick(); tick(); tick();
        check("bad_err_tied", err, 0);
        counts[11:8] = 4'd4;
`endif

        // Reset in the middle of a flush.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("rst2_err", err, 0);
        base = nib_q.size();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("midflush_vld", out_vld, 1);
        rst_n = 1'b0;
        #1;
        check("midflush_rst_vld", out_vld, 0);
        check("midflush_rst_rdy", in_rdy, 1);
        tick(); tick();
        check_stream("midflush_nibs", base, 1, 16'h0);
        rst_n = 1'b1;
        tick();
        check("post_rst_rdy", in_rdy, 1);
        do_flush("flush_post_rst", 16'h0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
